// File: rtl/prco_uart_rx_pkg.sv
// Shared constants for the prco UART receive path: FSM encoding and default bit timing.
package prco_uart_rx_pkg;

    localparam int PRCO_UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        URX_IDLE  = 3'd0,
        URX_START = 3'd1,
        URX_DATA  = 3'd2,
        URX_STOP  = 3'd3,
        URX_WAIT  = 3'd4
    } urx_state_t;

endpackage

// File: rtl/prco_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-bit pointers for full/empty/count.
module prco_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         q_data,
    output logic                     q_empty,
    output logic                     q_full,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign q_count = wr_ptr - rd_ptr;
    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == (AW+1)'(DEPTH));
    assign pop_ok  = i_pop && !q_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = i_push && (!q_full || pop_ok);
    assign q_data  = q_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/prco_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, FWFT byte buffer, sticky errors.
module prco_uart_rx
    import prco_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = PRCO_UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rx,
    input  logic                          i_pop,
    input  logic                          i_clear_err,
    output logic [7:0]                    q_data,
    output logic                          q_empty,
    output logic                          q_full,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          q_frame_err,
    output logic                          q_overrun,
    output logic                          q_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    urx_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;
    logic          tick;
    logic          stop_good;
    logic          stop_bad;
    logic          pop_ok;
    logic          push;

    assign tick      = (cnt == '0);
    assign stop_good = (state == URX_STOP) && tick && rx_s;
    assign stop_bad  = (state == URX_STOP) && tick && !rx_s;
    assign pop_ok    = i_pop && !q_empty;
    assign push      = stop_good && (!q_full || pop_ok);
    assign q_irq     = !q_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= URX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                URX_IDLE: begin
                    if (!rx_s) begin
                        state <= URX_START;
                        cnt   <= HALF_M1;
                    end
                end
                URX_START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= URX_DATA;
                        bit_idx <= '0;
                        cnt     <= FULL_M1;
                    end else begin
                        state <= URX_IDLE;
                    end
                end
                URX_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= FULL_M1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= URX_STOP;
                    end
                end
                URX_STOP: begin
                    if (!tick)     cnt   <= cnt - 1'b1;
                    else if (rx_s) state <= URX_IDLE;
                    else           state <= URX_WAIT;
                end
                URX_WAIT: begin
                    // Hold off on a break so a long low line cannot start a false frame.
                    if (rx_s) state <= URX_IDLE;
                end
                default: state <= URX_IDLE;
            endcase
        end
    end

    // Clear first so a same-cycle set takes priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_frame_err <= 1'b0;
            q_overrun   <= 1'b0;
        end else begin
            if (i_clear_err) begin
                q_frame_err <= 1'b0;
                q_overrun   <= 1'b0;
            end
            if (stop_bad)                        q_frame_err <= 1'b1;
            if (stop_good && q_full && !pop_ok)  q_overrun   <= 1'b1;
        end
    end

    prco_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (shreg),
        .i_pop   (i_pop),
        .q_data  (q_data),
        .q_empty (q_empty),
        .q_full  (q_full),
        .q_count (q_count)
    );

endmodule

// File: tb/tb_prco_uart_rx.sv
// Directed + randomized bench for prco_uart_rx against a queue-based frame model.
module tb_prco_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 8;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_pop = 1'b0;
    logic       i_clear_err = 1'b0;
    logic [7:0] q_data;
    logic       q_empty, q_full, q_frame_err, q_overrun, q_irq;
    logic [3:0] q_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] m_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    logic armed = 1'b0, fall_seen = 1'b0, prev_empty = 1'b1;
    int   fall_cyc = 0;

    prco_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx), .i_pop(i_pop),
        .i_clear_err(i_clear_err), .q_data(q_data), .q_empty(q_empty),
        .q_full(q_full), .q_count(q_count), .q_frame_err(q_frame_err),
        .q_overrun(q_overrun), .q_irq(q_irq)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (armed && !fall_seen && prev_empty && !q_empty) begin
            fall_seen = 1'b1;
            fall_cyc  = cyc;
        end
        prev_empty = q_empty;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        i_rx = v;
        idle(CPB);
    endtask

    // Ideal 8N1 driver; the line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        bit_out(1'b0);
        for (int k = 0; k < 8; k++) bit_out(d[k]);
        bit_out(stop);
    endtask

    // Reference: a frame either lands in the buffer, is dropped as overrun, or is a framing error.
    task automatic model_frame(input logic [7:0] d, input logic stop_ok);
        if (!stop_ok)                m_ferr = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(d);
        else                         m_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(q_count), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(q_empty), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(q_full),  32'(m_q.size() == DEPTH));
        chk({tag, ".irq"},   32'(q_irq),   32'(m_q.size() != 0));
        chk({tag, ".ferr"},  32'(q_frame_err), 32'(m_ferr));
        chk({tag, ".ovr"},   32'(q_overrun),   32'(m_ovr));
        if (m_q.size() != 0) chk({tag, ".data"}, 32'(q_data), 32'(m_q[0]));
    endtask

    task automatic pop_one(input string tag);
        if (m_q.size() == 0) begin
            chk({tag, ".nonempty"}, 32'(q_empty), 32'd0);
        end else begin
            chk({tag, ".data"}, 32'(q_data), 32'(m_q[0]));
            i_pop = 1'b1;
            idle(1);
            i_pop = 1'b0;
            void'(m_q.pop_front());
        end
    endtask

    task automatic clear_err();
        i_clear_err = 1'b1;
        idle(1);
        i_clear_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        logic [7:0] fill [8];
        logic [7:0] d;
        int c0;
        fill = '{8'h00, 8'hFF, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        idle(3);
        chk("rst.data", 32'(q_data), 32'd0);
        check_state("rst");
        i_reset = 1'b0;
        idle(2 * CPB);

        // Single byte with exact latency
        c0 = cyc;
        armed = 1'b1;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        idle(1);
        armed = 1'b0;
        chk("single.seen", 32'(fall_seen), 32'd1);
        chk("single.latency", 32'(fall_cyc - c0), 32'd79);
        check_state("single");
        pop_one("single.pop");
        check_state("single.after_pop");

        // Fill, overrun, drain in order
        for (int i = 0; i < 8; i++) begin
            send_frame(fill[i], 1'b1);
            model_frame(fill[i], 1'b1);
        end
        idle(1);
        check_state("fill");
        send_frame(8'h77, 1'b1);
        model_frame(8'h77, 1'b1);
        idle(1);
        check_state("overrun");
        for (int i = 0; i < 8; i++) begin
            chk("order.expect", 32'(q_data), 32'(fill[i]));
            pop_one("order.pop");
        end
        check_state("drained");
        clear_err();
        check_state("ovr_clear");

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        idle(20 * CPB);
        i_rx = 1'b1;
        idle(2 * CPB);
        check_state("ferr");
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        idle(1);
        check_state("ferr.next");
        clear_err();
        check_state("ferr_clear");
        pop_one("ferr.pop");

        // Short glitch is rejected
        i_rx = 1'b0;
        idle(2);
        i_rx = 1'b1;
        idle(3 * CPB);
        check_state("glitch");

        // Random frames with occasional bad stop bits
        for (int i = 0; i < 6; i++) begin
            logic ok;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            model_frame(d, ok);
            if (!ok) begin
                idle($urandom_range(1, 3) * CPB);
                i_rx = 1'b1;
                idle(CPB);
            end
            idle(1);
            check_state("rand");
        end
        while (m_q.size() != 0) pop_one("rand.drain");
        clear_err();
        check_state("rand.clear");

        // Full FIFO with a pop exactly on the stop-sample cycle
        for (int i = 0; i < 8; i++) begin
            fill[i] = 8'($urandom);
            send_frame(fill[i], 1'b1);
            model_frame(fill[i], 1'b1);
        end
        idle(1);
        check_state("full2");
        c0 = cyc;
        fork
            send_frame(8'h99, 1'b1);
            begin
                idle(78 - (cyc - c0));
                chk("popstop.data", 32'(q_data), 32'(m_q[0]));
                i_pop = 1'b1;
                idle(1);
                i_pop = 1'b0;
            end
        join
        void'(m_q.pop_front());
        model_frame(8'h99, 1'b1);
        idle(1);
        check_state("popstop");
        for (int i = 0; i < 8; i++) pop_one("popstop.drain");
        chk("popstop.empty", 32'(q_empty), 32'd1);

        // Reset in the middle of data bit 4
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        d = 8'h42;
        bit_out(1'b0);
        for (int k = 0; k < 4; k++) bit_out(d[k]);
        i_rx = d[4];
        idle(CPB / 2);
        i_reset = 1'b1;
        i_rx = 1'b1;
        idle(3);
        i_reset = 1'b0;
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        chk("midrst.data", 32'(q_data), 32'd0);
        check_state("midrst");
        idle(2 * CPB);
        check_state("midrst.idle");
        send_frame(8'h42, 1'b1);
        model_frame(8'h42, 1'b1);
        idle(1);
        check_state("midrst.next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
